// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Purpose:
//   Synchroniser and debouncer for raw board switch/button inputs. Each channel
//   passes through a 2-flop synchroniser. A small FSM then accepts a new level
//   only after the synchronised input has held that value for DEBOUNCE_CYCLES
//   consecutive clock samples. The clean level drives the gate-level logic
//   directly. One-cycle rise/fall strobes are also produced for counters and
//   display logic. All channels are fully independent.
//
// Parameters:
//   N_CH             number of input channels (>= 1)
//   DEBOUNCE_CYCLES  consecutive samples needed before the level flips (>= 2)
//   CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk     in   1     board clock, all logic on the rising edge
//   reset   in   1     synchronous, active-high reset
//   raw_in  in   N_CH  asynchronous raw switch/button inputs
//   level   out  N_CH  debounced level per channel (registered)
//   rise    out  N_CH  one-cycle pulse when level[i] goes 0->1
//   fall    out  N_CH  one-cycle pulse when level[i] goes 1->0
// -----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    typedef enum logic [1:0] {
        LOW_STABLE,
        WAIT_HIGH,
        HIGH_STABLE,
        WAIT_LOW
    } state_t;

    // Counter value on the sample that completes a transition. The count
    // starts at 1 on the first sample of the new value, so this is the
    // DEBOUNCE_CYCLES-th consecutive sample. The counter never passes it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value and the two sync stages form a real chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_level;
        logic             w_level_nxt;
        logic             r_rise;
        logic             w_rise_nxt;
        logic             r_fall;
        logic             w_fall_nxt;
        logic             w_in;

        assign w_in = r_sync2[g];

        // NOTE: every signal written here gets a default first. A path that
        // leaves one unassigned would infer a latch. The strobes default to 0
        // so that each one lasts a single cycle.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_rise_nxt  = 1'b0;
            w_fall_nxt  = 1'b0;

            case (r_state)
                LOW_STABLE: begin
                    w_level_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    if (w_in) begin
                        w_state_nxt = WAIT_HIGH;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!w_in) begin
                        // Bounce back to the stable value: abort without a pulse.
                        w_state_nxt = LOW_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = HIGH_STABLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                HIGH_STABLE: begin
                    w_level_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    if (!w_in) begin
                        w_state_nxt = WAIT_LOW;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (w_in) begin
                        w_state_nxt = HIGH_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = LOW_STABLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = LOW_STABLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end
            endcase
        end

        // NOTE: reset is synchronous and clears every flop, including the
        // counter. A reset in the middle of a debounce therefore drops the
        // pending transition rather than resuming it after release.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= LOW_STABLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
            end
        end

        assign level[g] = r_level;
        assign rise[g]  = r_rise;
        assign fall[g]  = r_fall;
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Self-checking bench for switch_debouncer. Two instances share one clock:
//   dut_a : DEBOUNCE_CYCLES=4, level change DEBOUNCE_CYCLES+2 = 6 edges after
//           the raw value is driven
//   dut_b : DEBOUNCE_CYCLES=2, the minimum setting
// Each directed step pushes the expected level and strobes onto a scoreboard
// queue, tagged with the cycle in which they must appear. On every cycle the
// bench compares both instances. A cycle with no queued entry expects the last
// known level and no strobes, so spurious or mistimed pulses are caught.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [1:0] raw_a, raw_b;
    logic [1:0] level_a, rise_a, fall_a;
    logic [1:0] level_b, rise_b, fall_b;

    always #5 clk = ~clk;

    switch_debouncer #(.N_CH(2), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut_a (
        .clk    (clk),
        .reset  (rst_a),
        .raw_in (raw_a),
        .level  (level_a),
        .rise   (rise_a),
        .fall   (fall_a)
    );

    switch_debouncer #(.N_CH(2), .DEBOUNCE_CYCLES(2), .CNT_W(2)) dut_b (
        .clk    (clk),
        .reset  (rst_b),
        .raw_in (raw_b),
        .level  (level_b),
        .rise   (rise_b),
        .fall   (fall_b)
    );

    typedef struct {
        string      tag;
        int         cyc;
        int         dut;
        logic [1:0] level;
        logic [1:0] rise;
        logic [1:0] fall;
    } exp_t;

    exp_t       sb[$];
    int         cyc     = 0;
    int         n_total = 0;
    int         n_pass  = 0;
    logic [1:0] exp_lvl [2];

    task automatic check(input string tag, input string what, input int dut,
                         input logic [1:0] obs, input logic [1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d %s at cycle %0d: observed %b expected %b",
                    tag, dut, what, cyc, obs, exp);
    endtask

    // Queue an expectation 'lat' edges from now. Pushes are made in
    // increasing cycle order.
    task automatic expect_at(input int dut, input string tag, input int lat,
                             input logic [1:0] lvl, input logic [1:0] r,
                             input logic [1:0] f);
        exp_t e;
        e.tag   = tag;
        e.cyc   = cyc + lat;
        e.dut   = dut;
        e.level = lvl;
        e.rise  = r;
        e.fall  = f;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t       e;
        logic [1:0] el [2];
        logic [1:0] er [2];
        logic [1:0] ef [2];
        string      tg [2];
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            el[d] = exp_lvl[d];
            er[d] = 2'b00;
            ef[d] = 2'b00;
            tg[d] = "steady";
        end
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            e            = sb.pop_front();
            el[e.dut]    = e.level;
            er[e.dut]    = e.rise;
            ef[e.dut]    = e.fall;
            tg[e.dut]    = e.tag;
            exp_lvl[e.dut] = e.level;
        end
        check(tg[0], "level", 0, level_a, el[0]);
        check(tg[0], "rise",  0, rise_a,  er[0]);
        check(tg[0], "fall",  0, fall_a,  ef[0]);
        check(tg[1], "level", 1, level_b, el[1]);
        check(tg[1], "rise",  1, rise_b,  er[1]);
        check(tg[1], "fall",  1, fall_b,  ef[1]);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        exp_lvl[0] = 2'b00;
        exp_lvl[1] = 2'b00;
        rst_a = 1'b1;
        rst_b = 1'b1;
        raw_a = 2'b11;
        raw_b = 2'b00;

        // Reset with both raw inputs high: outputs stay clear.
        run(3);

        // Release: both channels debounce together, 6 edges later.
        rst_a = 1'b0;
        expect_at(0, "rst_release", 6, 2'b11, 2'b11, 2'b00);
        run(8);

        // Both channels fall on the same edge.
        raw_a = 2'b00;
        expect_at(0, "both_fall", 6, 2'b00, 2'b00, 2'b11);
        run(8);

        // ch0 alone rises, ch1 untouched.
        raw_a = 2'b01;
        expect_at(0, "ch0_rise", 6, 2'b01, 2'b01, 2'b00);
        run(8);

        // Bring ch0 low again, then bounce it.
        raw_a = 2'b00;
        expect_at(0, "ch0_fall", 6, 2'b00, 2'b00, 2'b01);
        run(8);
        raw_a = 2'b01; tick();
        raw_a = 2'b00; tick();
        raw_a = 2'b01; tick();
        raw_a = 2'b01; tick();
        raw_a = 2'b00; tick();
        raw_a = 2'b01;
        expect_at(0, "bounce_settle", 6, 2'b01, 2'b01, 2'b00);
        run(8);

        // ch1 rising, reset lands on the edge before it would complete.
        raw_a = 2'b11;
        run(4);
        rst_a = 1'b1;
        expect_at(0, "mid_reset", 1, 2'b00, 2'b00, 2'b00);
        run(2);
        rst_a = 1'b0;
        expect_at(0, "post_reset", 6, 2'b11, 2'b11, 2'b00);
        run(8);

        // Minimum debounce length on dut_b.
        rst_b = 1'b0;
        run(3);
        raw_b = 2'b11; tick();
        raw_b = 2'b00;
        run(6);
        raw_b = 2'b01;
        expect_at(1, "min_hold_rise", 4, 2'b01, 2'b01, 2'b00);
        expect_at(1, "min_hold_fall", 6, 2'b00, 2'b00, 2'b01);
        run(2);
        raw_b = 2'b00;
        run(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
